// File: rtl/id_pipe_stage.sv
// -----------------------------------------------------------------------------
// id_pipe_stage
//
// Registered RV32I instruction-decode stage. Holds the architectural register
// file, decodes the main control bits and the immediate of the instruction
// offered by fetch, and registers the resulting bundle for execute. Both sides
// use a valid/ready handshake. Also provides:
//   - load-use stalling against the load currently held at the output,
//   - write-through of the writeback port into the operand read (BYPASS=1),
//   - flush of the held and the incoming instruction,
//   - refresh of held operand values when writeback targets them.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        fetch handshake
//   in_instr, in_pc          instruction word and its PC
//   flush                    drop held bundle and incoming instruction
//   wb_en, wb_rd, wb_data    register-file write port (writeback)
//   out_valid/out_ready      execute handshake
//   out_pc, out_rs1_data, out_rs2_data, out_imm
//                            PC, operand values, sign-extended immediate
//   out_rs1, out_rs2, out_rd register indices, 0 when the field is unused
//   out_funct3, out_funct7b5 raw funct3 and instruction bit 30
//   out_reg_write .. out_illegal
//                            main-control bits
// -----------------------------------------------------------------------------
module id_pipe_stage #(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 32,
  parameter bit BYPASS    = 1'b1,
  localparam int AW       = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_pc,

  input  logic             flush,

  input  logic             wb_en,
  input  logic [AW-1:0]    wb_rd,
  input  logic [WIDTH-1:0] wb_data,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_rs1_data,
  output logic [WIDTH-1:0] out_rs2_data,
  output logic [WIDTH-1:0] out_imm,
  output logic [AW-1:0]    out_rs1,
  output logic [AW-1:0]    out_rs2,
  output logic [AW-1:0]    out_rd,
  output logic [2:0]       out_funct3,
  output logic             out_funct7b5,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_mem_to_reg,
  output logic             out_alu_src,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_illegal
);

  // ---------------------------------------------------------------------------
  // Opcodes and immediate formats
  // ---------------------------------------------------------------------------
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  // Everything that execute receives, registered as one unit.
  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic [WIDTH-1:0] imm;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [AW-1:0]    rd;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic             branch;
    logic             jump;
    logic             illegal;
  } bundle_t;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] regs [REG_COUNT];
  logic             wb_write;

  assign wb_write = wb_en && (wb_rd != '0);

  // NOTE: the register file is cleared by reset because the architectural
  // state must start at zero; arrays that need no defined start value are
  // better left out of the reset branch so they can map onto RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_write) begin
      // NOTE: all clocked state uses non-blocking assignments so every
      // register samples pre-edge values regardless of process order.
      regs[wb_rd] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Main-control decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [6:0]       opcode;
  logic             use_rs1;
  logic             use_rs2;
  logic             use_rd;
  imm_fmt_e         imm_fmt;
  logic             c_mem_read;
  logic             c_mem_write;
  logic             c_mem_to_reg;
  logic             c_alu_src;
  logic             c_branch;
  logic             c_jump;
  logic             c_illegal;

  assign opcode = in_instr[6:0];

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path through the block leaves one unassigned and no latch is built.
  always_comb begin
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    use_rd       = 1'b0;
    imm_fmt      = FMT_NONE;
    c_mem_read   = 1'b0;
    c_mem_write  = 1'b0;
    c_mem_to_reg = 1'b0;
    c_alu_src    = 1'b0;
    c_branch     = 1'b0;
    c_jump       = 1'b0;
    c_illegal    = 1'b0;
    case (opcode)
      OP_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_IMM: begin
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        c_alu_src = 1'b1;
        imm_fmt   = FMT_I;
      end
      OP_LOAD: begin
        use_rs1      = 1'b1;
        use_rd       = 1'b1;
        c_alu_src    = 1'b1;
        c_mem_read   = 1'b1;
        c_mem_to_reg = 1'b1;
        imm_fmt      = FMT_I;
      end
      OP_STORE: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        c_alu_src   = 1'b1;
        c_mem_write = 1'b1;
        imm_fmt     = FMT_S;
      end
      OP_BRANCH: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        c_branch = 1'b1;
        imm_fmt  = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        use_rd    = 1'b1;
        c_alu_src = 1'b1;
        imm_fmt   = FMT_U;
      end
      OP_JAL: begin
        use_rd  = 1'b1;
        c_jump  = 1'b1;
        imm_fmt = FMT_J;
      end
      OP_JALR: begin
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        c_jump    = 1'b1;
        c_alu_src = 1'b1;
        imm_fmt   = FMT_I;
      end
      default: begin
        c_illegal = 1'b1;
      end
    endcase
  end

  // Register indices; only the low AW bits of each 5-bit field are used.
  logic [AW-1:0] dec_rs1;
  logic [AW-1:0] dec_rs2;
  logic [AW-1:0] dec_rd;

  assign dec_rs1 = use_rs1 ? in_instr[15 +: AW] : '0;
  assign dec_rs2 = use_rs2 ? in_instr[20 +: AW] : '0;
  assign dec_rd  = use_rd  ? in_instr[7 +: AW]  : '0;

  // ---------------------------------------------------------------------------
  // Immediate generator; each raw field is sign-extended by a signed cast.
  // ---------------------------------------------------------------------------
  logic [12:0]      b_raw;
  logic [20:0]      j_raw;
  logic [WIDTH-1:0] imm_i;
  logic [WIDTH-1:0] imm_s;
  logic [WIDTH-1:0] imm_b;
  logic [WIDTH-1:0] imm_u;
  logic [WIDTH-1:0] imm_j;
  logic [WIDTH-1:0] dec_imm;

  assign b_raw = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign j_raw = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  assign imm_i = WIDTH'($signed(in_instr[31:20]));
  assign imm_s = WIDTH'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = WIDTH'($signed(b_raw));
  assign imm_u = WIDTH'($signed({in_instr[31:12], 12'h000}));
  assign imm_j = WIDTH'($signed(j_raw));

  always_comb begin
    dec_imm = '0;
    case (imm_fmt)
      FMT_I:   dec_imm = imm_i;
      FMT_S:   dec_imm = imm_s;
      FMT_B:   dec_imm = imm_b;
      FMT_U:   dec_imm = imm_u;
      FMT_J:   dec_imm = imm_j;
      default: dec_imm = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand read with optional write-through from the writeback port
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rs1_rdata;
  logic [WIDTH-1:0] rs2_rdata;

  always_comb begin
    rs1_rdata = regs[dec_rs1];
    rs2_rdata = regs[dec_rs2];
    if (BYPASS && wb_write && (wb_rd == dec_rs1)) rs1_rdata = wb_data;
    if (BYPASS && wb_write && (wb_rd == dec_rs2)) rs2_rdata = wb_data;
    // x0 (and every unused operand, whose index is forced to 0) reads zero.
    if (dec_rs1 == '0) rs1_rdata = '0;
    if (dec_rs2 == '0) rs2_rdata = '0;
  end

  bundle_t dec_bundle;

  always_comb begin
    dec_bundle            = '0;
    dec_bundle.pc         = in_pc;
    dec_bundle.rs1_data   = rs1_rdata;
    dec_bundle.rs2_data   = rs2_rdata;
    dec_bundle.imm        = dec_imm;
    dec_bundle.rs1        = dec_rs1;
    dec_bundle.rs2        = dec_rs2;
    dec_bundle.rd         = dec_rd;
    dec_bundle.funct3     = in_instr[14:12];
    dec_bundle.funct7b5   = in_instr[30];
    dec_bundle.reg_write  = use_rd && (dec_rd != '0);
    dec_bundle.mem_read   = c_mem_read;
    dec_bundle.mem_write  = c_mem_write;
    dec_bundle.mem_to_reg = c_mem_to_reg;
    dec_bundle.alu_src    = c_alu_src;
    dec_bundle.branch     = c_branch;
    dec_bundle.jump       = c_jump;
    dec_bundle.illegal    = c_illegal;
  end

  // ---------------------------------------------------------------------------
  // Handshake and hazard detection
  // ---------------------------------------------------------------------------
  bundle_t q;
  logic    valid_q;
  logic    advance;
  logic    hazard;

  assign advance = !valid_q || out_ready;

  // Unused source indices are already forced to 0 and a load into x0 never
  // stalls, so a plain index match implies the operand is really read.
  assign hazard = valid_q && q.mem_read && (q.rd != '0) &&
                  ((dec_rs1 == q.rd) || (dec_rs2 == q.rd));

  // in_valid deliberately stays out of this term.
  assign in_ready = !rst && !flush && advance && !hazard;

  // ---------------------------------------------------------------------------
  // Output bundle register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (advance) begin
      if (in_valid && in_ready) begin
        q       <= dec_bundle;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end else if (wb_write) begin
      // Held bundle (valid and not taken): keep operands in step with the
      // register file so execute does not consume a stale value later.
      if (wb_rd == q.rs1) q.rs1_data <= wb_data;
      if (wb_rd == q.rs2) q.rs2_data <= wb_data;
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = q.pc;
  assign out_rs1_data   = q.rs1_data;
  assign out_rs2_data   = q.rs2_data;
  assign out_imm        = q.imm;
  assign out_rs1        = q.rs1;
  assign out_rs2        = q.rs2;
  assign out_rd         = q.rd;
  assign out_funct3     = q.funct3;
  assign out_funct7b5   = q.funct7b5;
  assign out_reg_write  = q.reg_write;
  assign out_mem_read   = q.mem_read;
  assign out_mem_write  = q.mem_write;
  assign out_mem_to_reg = q.mem_to_reg;
  assign out_alu_src    = q.alu_src;
  assign out_branch     = q.branch;
  assign out_jump       = q.jump;
  assign out_illegal    = q.illegal;

endmodule
